// File: rtl/uart_receiver_if.sv
// Receiver-side bundle: serial line and tick in, recovered byte and status out.
interface uart_receiver_if #(
  parameter int unsigned DBIT = 8
);
  logic            rx;
  logic            s_tick;
  logic [DBIT-1:0] d_out;
  logic            rx_done_flag;
  logic            frame_err;
  logic            busy;

  // Line/tick source side.
  modport master (
    output rx,
    output s_tick,
    input  d_out,
    input  rx_done_flag,
    input  frame_err,
    input  busy
  );

  // Receiver side.
  modport slave (
    input  rx,
    input  s_tick,
    output d_out,
    output rx_done_flag,
    output frame_err,
    output busy
  );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver, MSB first, oversampled by the s_tick pulse from the baud generator.
module uart_receiver #(
  parameter int unsigned DBIT     = 8,
  parameter int unsigned OS_TICKS = 16,
  parameter int unsigned SB_TICKS = 16
) (
  input  logic             clk,
  input  logic             reset,
  uart_receiver_if.slave   bus
);

  localparam int unsigned S_MAX   = (OS_TICKS > SB_TICKS) ? OS_TICKS : SB_TICKS;
  localparam int unsigned S_CNT_W = (S_MAX > 1) ? $clog2(S_MAX) : 1;
  localparam int unsigned N_CNT_W = (DBIT > 1) ? $clog2(DBIT) : 1;

  // Tick counts at which the FSM acts: mid start bit, mid data bit, mid stop bit.
  localparam logic [S_CNT_W-1:0] START_MID = S_CNT_W'(OS_TICKS / 2 - 1);
  localparam logic [S_CNT_W-1:0] BIT_END   = S_CNT_W'(OS_TICKS - 1);
  localparam logic [S_CNT_W-1:0] STOP_END  = S_CNT_W'(SB_TICKS - 1);
  localparam logic [N_CNT_W-1:0] LAST_BIT  = N_CNT_W'(DBIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [1:0]         sync_q;
  logic               rx_s;
  logic [S_CNT_W-1:0] s_cnt;
  logic [S_CNT_W-1:0] s_cnt_next;
  logic [N_CNT_W-1:0] n_cnt;
  logic [N_CNT_W-1:0] n_cnt_next;
  logic [DBIT-1:0]    shreg;
  logic [DBIT-1:0]    shreg_next;
  logic [DBIT-1:0]    d_out;
  logic [DBIT-1:0]    d_out_next;
  logic               done;
  logic               done_next;
  logic               ferr;
  logic               ferr_next;
  logic               busy;
  logic               busy_next;

  // Two-flop synchroniser for the asynchronous line; resets to the idle-high level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], bus.rx};
    end
  end

  assign rx_s = sync_q[1];

  // State register together with counters, shift register and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      s_cnt <= '0;
      n_cnt <= '0;
      shreg <= '0;
      d_out <= '0;
      done  <= 1'b0;
      ferr  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      s_cnt <= s_cnt_next;
      n_cnt <= n_cnt_next;
      shreg <= shreg_next;
      d_out <= d_out_next;
      done  <= done_next;
      ferr  <= ferr_next;
      busy  <= busy_next;
    end
  end

  // Next-state decision: start edge, mid-start validation, bit counting, stop sample.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
        end
      end
      START: begin
        if (bus.s_tick && (s_cnt == START_MID)) begin
          state_next = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bus.s_tick && (s_cnt == BIT_END) && (n_cnt == LAST_BIT)) begin
          state_next = STOP;
        end
      end
      STOP: begin
        if (bus.s_tick && (s_cnt == STOP_END)) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath and output updates; the done/error pulses default low every cycle.
  always_comb begin
    s_cnt_next = s_cnt;
    n_cnt_next = n_cnt;
    shreg_next = shreg;
    d_out_next = d_out;
    done_next  = 1'b0;
    ferr_next  = 1'b0;
    busy_next  = (state_next != IDLE);
    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          s_cnt_next = '0;
        end
      end
      START: begin
        if (bus.s_tick) begin
          if (s_cnt == START_MID) begin
            s_cnt_next = '0;
            n_cnt_next = '0;
          end else begin
            s_cnt_next = s_cnt + S_CNT_W'(1);
          end
        end
      end
      DATA: begin
        if (bus.s_tick) begin
          if (s_cnt == BIT_END) begin
            s_cnt_next = '0;
            shreg_next = {shreg[DBIT-2:0], rx_s};
            if (n_cnt != LAST_BIT) begin
              n_cnt_next = n_cnt + N_CNT_W'(1);
            end
          end else begin
            s_cnt_next = s_cnt + S_CNT_W'(1);
          end
        end
      end
      STOP: begin
        if (bus.s_tick) begin
          if (s_cnt == STOP_END) begin
            s_cnt_next = '0;
            d_out_next = shreg;
            done_next  = 1'b1;
            ferr_next  = ~rx_s;
          end else begin
            s_cnt_next = s_cnt + S_CNT_W'(1);
          end
        end
      end
      default: begin
        s_cnt_next = '0;
        n_cnt_next = '0;
      end
    endcase
  end

  assign bus.d_out        = d_out;
  assign bus.rx_done_flag = done;
  assign bus.frame_err    = ferr;
  assign bus.busy         = busy;

endmodule
